// File: rtl/sc_mmio_head_ctrl.sv
// Head-of-active-list SC/MMIO issue controller with LR reservation tracking.
// Issues the head SC/MMIO op to the LSU once, waits for completion, and keeps
// the LR reservation (address, size, timeout) that SC execution consults.
module sc_mmio_head_ctrl #(
    parameter int unsigned AL_IDX_WIDTH = 7,
    parameter int unsigned PADDR_WIDTH  = 56,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    head_valid,
    input  logic [AL_IDX_WIDTH-1:0] head_al_idx,
    input  logic                    head_is_sc,
    input  logic                    head_is_mmio,
    input  logic                    lr_commit_valid,
    input  logic [PADDR_WIDTH-1:0]  lr_commit_paddr,
    input  logic                    lr_commit_is_w,
    input  logic                    st_commit_valid,
    input  logic [PADDR_WIDTH-1:0]  st_commit_paddr,
    output logic                    exec_valid,
    input  logic                    exec_ready,
    output logic [AL_IDX_WIDTH-1:0] exec_al_idx,
    output logic                    exec_is_sc,
    output logic                    exec_has_lock,
    output logic [PADDR_WIDTH-1:0]  exec_lock_paddr,
    output logic                    exec_is_lr_w,
    input  logic                    done_valid,
    output logic                    busy
);

    localparam int unsigned CNT_WIDTH = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic                     done_seen_q;
    logic [AL_IDX_WIDTH-1:0]  done_idx_q;
    logic                     lock_valid_q;
    logic [PADDR_WIDTH-1:0]   lock_paddr_q;
    logic                     lock_is_w_q;
    logic [CNT_WIDTH-1:0]     lock_cnt_q;

    logic head_qual_c;
    logic op_done_c;
    logic st_match_c;
    logic lock_expire_c;

    // A head is eligible unless it is the op that just completed and has not yet retired
    assign head_qual_c   = head_valid && (head_is_sc || head_is_mmio) && !flush &&
                           !(done_seen_q && (head_al_idx == done_idx_q));
    assign op_done_c     = (state_q == WAIT) && done_valid && !flush;
    assign st_match_c    = st_commit_valid && (st_commit_paddr == lock_paddr_q);
    assign lock_expire_c = (lock_cnt_q == CNT_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition including the handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (head_qual_c) state_d = ISSUE;
            ISSUE:   if (exec_ready)  state_d = WAIT;
            WAIT:    if (done_valid)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Capture identity and kind of the op being issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_al_idx <= '0;
            exec_is_sc  <= 1'b0;
        end else if ((state_q == IDLE) && head_qual_c) begin
            exec_al_idx <= head_al_idx;
            exec_is_sc  <= head_is_sc;
        end
    end

    // Remember the completed op until the head moves past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_seen_q <= 1'b0;
            done_idx_q  <= '0;
        end else if (flush) begin
            done_seen_q <= 1'b0;
        end else if (op_done_c) begin
            done_seen_q <= 1'b1;
            done_idx_q  <= exec_al_idx;
        end else if (!head_valid || (head_al_idx != done_idx_q)) begin
            done_seen_q <= 1'b0;
        end
    end

    // LR reservation: flush > new LR > (store snoop, timeout, SC completion)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_valid_q <= 1'b0;
            lock_paddr_q <= '0;
            lock_is_w_q  <= 1'b0;
            lock_cnt_q   <= '0;
        end else if (flush) begin
            lock_valid_q <= 1'b0;
            lock_cnt_q   <= '0;
        end else if (lr_commit_valid) begin
            lock_valid_q <= 1'b1;
            lock_paddr_q <= lr_commit_paddr;
            lock_is_w_q  <= lr_commit_is_w;
            lock_cnt_q   <= '0;
        end else if (lock_valid_q && (st_match_c || lock_expire_c || (op_done_c && exec_is_sc))) begin
            lock_valid_q <= 1'b0;
            lock_cnt_q   <= '0;
        end else if (lock_valid_q && !lock_expire_c) begin
            lock_cnt_q   <= lock_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign exec_valid      = (state_q == ISSUE);
    assign busy            = (state_q != IDLE);
    assign exec_has_lock   = lock_valid_q;
    assign exec_lock_paddr = lock_paddr_q;
    assign exec_is_lr_w    = lock_is_w_q;

endmodule
